// File: rtl/hazard_pkg.sv
// -----------------------------------------------------------------------------
// hazard_pkg
// Shared definitions for the pipeline hazard controller:
//   - hazard_state_e        : controller states (RUN / MEM_WAIT / ABORT)
//   - HAZ_MAX_MEM_WAIT_DEF  : default number of frozen MEM_WAIT cycles before abort
//   - HAZ_CNT_W             : width of the performance counters
// -----------------------------------------------------------------------------
package hazard_pkg;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MEM_WAIT = 2'd1,
    ABORT    = 2'd2
  } hazard_state_e;

  localparam int HAZ_MAX_MEM_WAIT_DEF = 15;
  localparam int HAZ_CNT_W            = 32;

endpackage : hazard_pkg

// File: rtl/hazard_perf_counters.sv
// -----------------------------------------------------------------------------
// hazard_perf_counters
// Three saturating event counters for the hazard controller. Only instantiated
// when HAZ_STATS_EN is defined.
// Ports:
//   clk, rst_n        : clock, asynchronous active-low reset (counters clear)
//   stall_inc         : count one stall cycle (PC not written)
//   load_use_inc      : count one applied load-use bubble
//   flush_inc         : count one applied branch flush
//   stall_cycles,
//   load_use_count,
//   flush_count       : counter values, saturating at all-ones
// -----------------------------------------------------------------------------
module hazard_perf_counters
  import hazard_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 stall_inc,
  input  logic                 load_use_inc,
  input  logic                 flush_inc,
  output logic [HAZ_CNT_W-1:0] stall_cycles,
  output logic [HAZ_CNT_W-1:0] load_use_count,
  output logic [HAZ_CNT_W-1:0] flush_count
);

  function automatic logic [HAZ_CNT_W-1:0] sat_inc(input logic [HAZ_CNT_W-1:0] v);
    if (&v) sat_inc = v;
    else    sat_inc = v + HAZ_CNT_W'(1);
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cycles   <= '0;
      load_use_count <= '0;
      flush_count    <= '0;
    end else begin
      if (stall_inc)    stall_cycles   <= sat_inc(stall_cycles);
      if (load_use_inc) load_use_count <= sat_inc(load_use_count);
      if (flush_inc)    flush_count    <= sat_inc(flush_count);
    end
  end

endmodule : hazard_perf_counters

// File: rtl/hazard_detection_unit.sv
// -----------------------------------------------------------------------------
// hazard_detection_unit
// Stall / flush / memory-wait controller for the 5-stage RISC-V pipeline.
// Handles load-use bubbles, branch-taken flushes and whole-pipeline freezes
// while data memory is not ready (with timeout abort). All hazard outputs are
// Mealy (same-cycle) functions of the current state and inputs.
//
// Optional feature macro: HAZ_STATS_EN adds three saturating performance
// counters (stall_cycles, load_use_count, flush_count) and their ports.
//
// Ports:
//   clk, rst_n                      : clock, asynchronous active-low reset
//   IF_ID_rs1/rs2, IF_ID_uses_rs1/2 : source regs of the ID instruction
//   ID_EX_rd, ID_EX_MemRead         : destination / load flag of EX instruction
//   EX_branch_taken                 : branch/jump resolved taken in EX
//   dmem_req, dmem_ready            : MEM-stage access handshake
//   PC_Write..EX_MEM_Write          : pipeline register write enables
//   IF_ID_Flush, ID_EX_Flush,
//   MEM_WB_Flush                    : bubble insertion on next edge
//   dmem_abort                      : cancel the outstanding access
//   mem_timeout                     : sticky, set when an access is aborted
//   stall_cycles, load_use_count,
//   flush_count                     : performance counters (HAZ_STATS_EN)
// -----------------------------------------------------------------------------
module hazard_detection_unit
  import hazard_pkg::*;
#(
  parameter int MAX_MEM_WAIT = HAZ_MAX_MEM_WAIT_DEF,
  parameter int WAIT_CNT_W   = $clog2(MAX_MEM_WAIT + 1)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [4:0]           IF_ID_rs1,
  input  logic [4:0]           IF_ID_rs2,
  input  logic                 IF_ID_uses_rs1,
  input  logic                 IF_ID_uses_rs2,
  input  logic [4:0]           ID_EX_rd,
  input  logic                 ID_EX_MemRead,
  input  logic                 EX_branch_taken,
  input  logic                 dmem_req,
  input  logic                 dmem_ready,
  output logic                 PC_Write,
  output logic                 IF_ID_Write,
  output logic                 ID_EX_Write,
  output logic                 EX_MEM_Write,
  output logic                 IF_ID_Flush,
  output logic                 ID_EX_Flush,
  output logic                 MEM_WB_Flush,
  output logic                 dmem_abort,
  output logic                 mem_timeout
`ifdef HAZ_STATS_EN
  ,
  output logic [HAZ_CNT_W-1:0] stall_cycles,
  output logic [HAZ_CNT_W-1:0] load_use_count,
  output logic [HAZ_CNT_W-1:0] flush_count
`endif
);

  localparam logic [WAIT_CNT_W-1:0] WAIT_LIMIT = WAIT_CNT_W'(MAX_MEM_WAIT);

  hazard_state_e           state, state_d;
  logic [WAIT_CNT_W-1:0]   wait_cnt, wait_cnt_d;
  logic                    mem_timeout_d;

  logic memwait;
  logic load_use;
  logic freeze;

  assign memwait  = dmem_req && !dmem_ready;
  assign load_use = ID_EX_MemRead && (ID_EX_rd != 5'd0) &&
                    ((IF_ID_uses_rs1 && (ID_EX_rd == IF_ID_rs1)) ||
                     (IF_ID_uses_rs2 && (ID_EX_rd == IF_ID_rs2)));
  assign freeze   = ((state == RUN) || (state == MEM_WAIT)) && memwait;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= RUN;
      wait_cnt    <= '0;
      mem_timeout <= 1'b0;
    end else begin
      state       <= state_d;
      wait_cnt    <= wait_cnt_d;
      mem_timeout <= mem_timeout_d;
    end
  end

  // Next-state and Mealy outputs
  always_comb begin
    state_d       = state;
    wait_cnt_d    = wait_cnt;
    mem_timeout_d = mem_timeout;

    PC_Write      = 1'b1;
    IF_ID_Write   = 1'b1;
    ID_EX_Write   = 1'b1;
    EX_MEM_Write  = 1'b1;
    IF_ID_Flush   = 1'b0;
    ID_EX_Flush   = 1'b0;
    MEM_WB_Flush  = 1'b0;
    dmem_abort    = 1'b0;

    // Output priority: freeze > abort > branch > load-use. A frozen EX
    // instruction keeps presenting its branch/load-use condition, so
    // suppressing it here does not lose it.
    if (freeze) begin
      PC_Write     = 1'b0;
      IF_ID_Write  = 1'b0;
      ID_EX_Write  = 1'b0;
      EX_MEM_Write = 1'b0;
      MEM_WB_Flush = 1'b1;
    end else if (state == ABORT) begin
      MEM_WB_Flush = 1'b1;
      dmem_abort   = 1'b1;
    end else if (EX_branch_taken) begin
      IF_ID_Flush  = 1'b1;
      ID_EX_Flush  = 1'b1;
    end else if (load_use) begin
      PC_Write     = 1'b0;
      IF_ID_Write  = 1'b0;
      ID_EX_Flush  = 1'b1;
    end

    case (state)
      RUN: begin
        if (memwait) begin
          state_d    = MEM_WAIT;
          wait_cnt_d = WAIT_CNT_W'(1);
        end
      end
      MEM_WAIT: begin
        // Leaving on !memwait (ready seen, or the request withdrawn) keeps the
        // state consistent with the freeze condition. Ready beats the limit.
        if (!memwait) begin
          state_d    = RUN;
          wait_cnt_d = '0;
        end else if (wait_cnt == WAIT_LIMIT) begin
          state_d    = ABORT;
          wait_cnt_d = '0;
        end else begin
          wait_cnt_d = wait_cnt + WAIT_CNT_W'(1);
        end
      end
      ABORT: begin
        state_d       = RUN;
        wait_cnt_d    = '0;
        mem_timeout_d = 1'b1;
      end
      default: begin
        state_d    = RUN;
        wait_cnt_d = '0;
      end
    endcase
  end

`ifdef HAZ_STATS_EN
  logic lu_applied;
  logic br_applied;

  assign br_applied = !freeze && (state != ABORT) && EX_branch_taken;
  assign lu_applied = !freeze && (state != ABORT) && !EX_branch_taken && load_use;

  hazard_perf_counters u_perf (
    .clk            (clk),
    .rst_n          (rst_n),
    .stall_inc      (!PC_Write),
    .load_use_inc   (lu_applied),
    .flush_inc      (br_applied),
    .stall_cycles   (stall_cycles),
    .load_use_count (load_use_count),
    .flush_count    (flush_count)
  );
`endif

endmodule : hazard_detection_unit

// File: tb/tb_hazard_detection_unit.sv
// -----------------------------------------------------------------------------
// tb_hazard_detection_unit
// Directed self-checking bench for hazard_detection_unit (MAX_MEM_WAIT = 4).
// Output vector order: {PC_Write, IF_ID_Write, ID_EX_Write, EX_MEM_Write,
//                       IF_ID_Flush, ID_EX_Flush, MEM_WB_Flush, dmem_abort,
//                       mem_timeout}
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_hazard_detection_unit;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [4:0] IF_ID_rs1, IF_ID_rs2, ID_EX_rd;
  logic       IF_ID_uses_rs1, IF_ID_uses_rs2, ID_EX_MemRead;
  logic       EX_branch_taken, dmem_req, dmem_ready;
  logic       PC_Write, IF_ID_Write, ID_EX_Write, EX_MEM_Write;
  logic       IF_ID_Flush, ID_EX_Flush, MEM_WB_Flush, dmem_abort, mem_timeout;
`ifdef HAZ_STATS_EN
  logic [31:0] stall_cycles, load_use_count, flush_count;
`endif

  int cmp_cnt  = 0;
  int fail_cnt = 0;

  localparam logic [8:0] V_IDLE  = 9'b1111_000_0_0;
  localparam logic [8:0] V_LU    = 9'b0011_010_0_0;
  localparam logic [8:0] V_BR    = 9'b1111_110_0_0;
  localparam logic [8:0] V_FRZ   = 9'b0000_001_0_0;
  localparam logic [8:0] V_ABT   = 9'b1111_001_1_0;
  localparam logic [8:0] V_IDLET = 9'b1111_000_0_1;

  logic [8:0] outs;
  assign outs = {PC_Write, IF_ID_Write, ID_EX_Write, EX_MEM_Write,
                 IF_ID_Flush, ID_EX_Flush, MEM_WB_Flush, dmem_abort, mem_timeout};

  always #5 clk = ~clk;

  hazard_detection_unit #(.MAX_MEM_WAIT(4)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .IF_ID_rs1       (IF_ID_rs1),
    .IF_ID_rs2       (IF_ID_rs2),
    .IF_ID_uses_rs1  (IF_ID_uses_rs1),
    .IF_ID_uses_rs2  (IF_ID_uses_rs2),
    .ID_EX_rd        (ID_EX_rd),
    .ID_EX_MemRead   (ID_EX_MemRead),
    .EX_branch_taken (EX_branch_taken),
    .dmem_req        (dmem_req),
    .dmem_ready      (dmem_ready),
    .PC_Write        (PC_Write),
    .IF_ID_Write     (IF_ID_Write),
    .ID_EX_Write     (ID_EX_Write),
    .EX_MEM_Write    (EX_MEM_Write),
    .IF_ID_Flush     (IF_ID_Flush),
    .ID_EX_Flush     (ID_EX_Flush),
    .MEM_WB_Flush    (MEM_WB_Flush),
    .dmem_abort      (dmem_abort),
    .mem_timeout     (mem_timeout)
`ifdef HAZ_STATS_EN
    ,
    .stall_cycles    (stall_cycles),
    .load_use_count  (load_use_count),
    .flush_count     (flush_count)
`endif
  );

  task automatic idle_inputs();
    IF_ID_rs1 = 5'd0; IF_ID_rs2 = 5'd0; ID_EX_rd = 5'd0;
    IF_ID_uses_rs1 = 1'b0; IF_ID_uses_rs2 = 1'b0; ID_EX_MemRead = 1'b0;
    EX_branch_taken = 1'b0; dmem_req = 1'b0; dmem_ready = 1'b0;
  endtask

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst_n = 1'b0; #1; rst_n = 1'b1;
    tick();
  endtask

  task automatic test_reset();
    idle_inputs();
    rst_n = 1'b0; #2;
    cmp_cnt++;
    if (outs !== V_IDLE) begin
      fail_cnt++; $display("FAIL reset_outs got %b expected %b", outs, V_IDLE);
    end
`ifdef HAZ_STATS_EN
    cmp_cnt++;
    if ({stall_cycles, load_use_count, flush_count} !== 96'd0) begin
      fail_cnt++; $display("FAIL reset_counters got %0d/%0d/%0d expected 0/0/0",
                           stall_cycles, load_use_count, flush_count);
    end
`endif
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_load_use();
    do_reset();
    ID_EX_MemRead = 1'b1; ID_EX_rd = 5'd5; IF_ID_rs2 = 5'd5; IF_ID_uses_rs2 = 1'b1;
    IF_ID_rs1 = 5'd3; IF_ID_uses_rs1 = 1'b1; #1;
    cmp_cnt++;
    if (outs !== V_LU) begin
      fail_cnt++; $display("FAIL load_use_rs2 got %b expected %b", outs, V_LU);
    end
    tick();
    idle_inputs(); #1;
    cmp_cnt++;
    if (outs !== V_IDLE) begin
      fail_cnt++; $display("FAIL load_use_one_bubble got %b expected %b", outs, V_IDLE);
    end
`ifdef HAZ_STATS_EN
    cmp_cnt++;
    if (load_use_count !== 32'd1) begin
      fail_cnt++; $display("FAIL load_use_count got %0d expected 1", load_use_count);
    end
`endif
    ID_EX_MemRead = 1'b1; ID_EX_rd = 5'd7; IF_ID_rs1 = 5'd7; IF_ID_uses_rs1 = 1'b1; #1;
    cmp_cnt++;
    if (outs !== V_LU) begin
      fail_cnt++; $display("FAIL load_use_rs1 got %b expected %b", outs, V_LU);
    end
    IF_ID_uses_rs1 = 1'b0; #1;
    cmp_cnt++;
    if (outs !== V_IDLE) begin
      fail_cnt++; $display("FAIL load_use_unused_rs1 got %b expected %b", outs, V_IDLE);
    end
    ID_EX_MemRead = 1'b0; IF_ID_uses_rs1 = 1'b1; #1;
    cmp_cnt++;
    if (outs !== V_IDLE) begin
      fail_cnt++; $display("FAIL not_a_load got %b expected %b", outs, V_IDLE);
    end
    tick();
    idle_inputs();
  endtask

  task automatic test_rd_zero();
    ID_EX_MemRead = 1'b1; ID_EX_rd = 5'd0; IF_ID_rs2 = 5'd0; IF_ID_uses_rs2 = 1'b1; #1;
    cmp_cnt++;
    if (outs !== V_IDLE) begin
      fail_cnt++; $display("FAIL rd_zero_guard got %b expected %b", outs, V_IDLE);
    end
    tick();
    idle_inputs();
  endtask

  task automatic test_branch_vs_load_use();
    do_reset();
    ID_EX_MemRead = 1'b1; ID_EX_rd = 5'd9; IF_ID_rs1 = 5'd9; IF_ID_uses_rs1 = 1'b1;
    EX_branch_taken = 1'b1; #1;
    cmp_cnt++;
    if (outs !== V_BR) begin
      fail_cnt++; $display("FAIL branch_over_load_use got %b expected %b", outs, V_BR);
    end
    tick();
    idle_inputs(); #1;
    cmp_cnt++;
    if (outs !== V_IDLE) begin
      fail_cnt++; $display("FAIL after_branch got %b expected %b", outs, V_IDLE);
    end
`ifdef HAZ_STATS_EN
    cmp_cnt++;
    if ({flush_count, load_use_count, stall_cycles} !== {32'd1, 32'd0, 32'd0}) begin
      fail_cnt++; $display("FAIL branch_counters got flush=%0d lu=%0d stall=%0d expected 1/0/0",
                           flush_count, load_use_count, stall_cycles);
    end
`endif
  endtask

  task automatic test_mem_wait();
    do_reset();
    dmem_req = 1'b1; dmem_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      EX_branch_taken = (i >= 1);
      #1;
      cmp_cnt++;
      if (outs !== V_FRZ) begin
        fail_cnt++; $display("FAIL mem_wait_freeze[%0d] got %b expected %b", i, outs, V_FRZ);
      end
      tick();
    end
    dmem_ready = 1'b1; EX_branch_taken = 1'b1; #1;
    cmp_cnt++;
    if (outs !== V_BR) begin
      fail_cnt++; $display("FAIL mem_wait_release_branch got %b expected %b", outs, V_BR);
    end
    tick();
    EX_branch_taken = 1'b0; #1;
    cmp_cnt++;
    if (outs !== V_IDLE) begin
      fail_cnt++; $display("FAIL mem_wait_back_to_run got %b expected %b", outs, V_IDLE);
    end
`ifdef HAZ_STATS_EN
    cmp_cnt++;
    if ({stall_cycles, flush_count} !== {32'd3, 32'd1}) begin
      fail_cnt++; $display("FAIL mem_wait_counters got stall=%0d flush=%0d expected 3/1",
                           stall_cycles, flush_count);
    end
`endif
    tick();
    idle_inputs();
  endtask

  task automatic test_ready_at_limit();
    do_reset();
    dmem_req = 1'b1; dmem_ready = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    dmem_ready = 1'b1; #1;
    cmp_cnt++;
    if (outs !== V_IDLE) begin
      fail_cnt++; $display("FAIL ready_at_limit got %b expected %b", outs, V_IDLE);
    end
    tick();
    idle_inputs(); #1;
    cmp_cnt++;
    if (outs !== V_IDLE) begin
      fail_cnt++; $display("FAIL ready_at_limit_no_abort got %b expected %b", outs, V_IDLE);
    end
  endtask

  task automatic test_timeout();
    do_reset();
    dmem_req = 1'b1; dmem_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      #1;
      cmp_cnt++;
      if (outs !== V_FRZ) begin
        fail_cnt++; $display("FAIL timeout_freeze[%0d] got %b expected %b", i, outs, V_FRZ);
      end
      tick();
    end
    #1;
    cmp_cnt++;
    if (outs !== V_ABT) begin
      fail_cnt++; $display("FAIL timeout_abort got %b expected %b", outs, V_ABT);
    end
    tick();
    dmem_req = 1'b0; #1;
    for (int i = 0; i < 2; i++) begin
      cmp_cnt++;
      if (outs !== V_IDLET) begin
        fail_cnt++; $display("FAIL timeout_sticky[%0d] got %b expected %b", i, outs, V_IDLET);
      end
      tick();
    end
`ifdef HAZ_STATS_EN
    cmp_cnt++;
    if (stall_cycles !== 32'd5) begin
      fail_cnt++; $display("FAIL timeout_stall_cycles got %0d expected 5", stall_cycles);
    end
`endif
  endtask

  task automatic test_reset_mid_wait();
    // mem_timeout is 1 from the previous test; enter MEM_WAIT then reset.
    dmem_req = 1'b1; dmem_ready = 1'b0;
    tick(); tick();
    rst_n = 1'b0; dmem_req = 1'b0; #2;
    cmp_cnt++;
    if (outs !== V_IDLE) begin
      fail_cnt++; $display("FAIL reset_mid_wait got %b expected %b", outs, V_IDLE);
    end
`ifdef HAZ_STATS_EN
    cmp_cnt++;
    if ({stall_cycles, load_use_count, flush_count} !== 96'd0) begin
      fail_cnt++; $display("FAIL reset_mid_wait_counters got %0d/%0d/%0d expected 0/0/0",
                           stall_cycles, load_use_count, flush_count);
    end
`endif
    rst_n = 1'b1;
    tick();
    // Reach the ABORT cycle and reset inside it: the abort must vanish.
    dmem_req = 1'b1;
    for (int i = 0; i < 5; i++) tick();
    dmem_req = 1'b0; rst_n = 1'b0; #2;
    cmp_cnt++;
    if (outs !== V_IDLE) begin
      fail_cnt++; $display("FAIL reset_mid_abort got %b expected %b", outs, V_IDLE);
    end
    rst_n = 1'b1;
    tick(); #1;
    cmp_cnt++;
    if (outs !== V_IDLE) begin
      fail_cnt++; $display("FAIL after_reset_mid_abort got %b expected %b", outs, V_IDLE);
    end
  endtask

  initial begin
    idle_inputs();
    rst_n = 1'b1;
    test_reset();
    test_load_use();
    test_rd_zero();
    test_branch_vs_load_use();
    test_mem_wait();
    test_ready_at_limit();
    test_timeout();
    test_reset_mid_wait();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, fail_cnt);
    $finish;
  end

endmodule : tb_hazard_detection_unit
